// File: rtl/instr_encoder.sv
// Instruction encoder: accepts one instruction request at a time, encodes it
// into a 32-bit MIPS-style word and writes it to sequential instruction-memory
// addresses. Illegal opcodes and a write past the last address raise a sticky
// error. A program load ends in DONE and is held there until clear or reset.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic        in_last,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        err,
    output logic [8:0]  count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_AND  = 4'd1,
        OP_OR   = 4'd2,
        OP_SUB  = 4'd3,
        OP_SLT  = 4'd4,
        OP_ADDI = 4'd5,
        OP_SW   = 4'd6,
        OP_LW   = 4'd7,
        OP_BEQ  = 4'd8
    } op_t;

    localparam logic [7:0] LAST_ADDR = 8'hFF;

    state_t      state;
    state_t      state_next;
    logic [7:0]  next_addr;   // address the next legal instruction will use
    logic        pend_last;   // in_last of the word currently being written
    logic        accept;
    logic        op_legal;
    logic [31:0] enc_word;

    // A transfer happens only in IDLE and never in a cycle where clear wins.
    assign in_ready = (state == ST_IDLE) && !clear;
    assign accept   = in_valid && in_ready;

    // Encode the request currently on the inputs and flag illegal opcodes.
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        enc_word = 32'h0000_0000;
        op_legal = 1'b1;
        case (in_op)
            OP_ADD:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
            OP_AND:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
            OP_OR:   enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
            OP_SUB:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
            OP_SLT:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
            OP_ADDI: enc_word = {6'b001000, in_rs, in_rt, in_imm};
            OP_SW:   enc_word = {6'b101011, in_rs, in_rt, in_imm};
            OP_LW:   enc_word = {6'b100011, in_rs, in_rt, in_imm};
            OP_BEQ:  enc_word = {6'b000100, in_rs, in_rt, in_imm};
            default: op_legal = 1'b0;
        endcase
    end

    // State register; reset drops straight to IDLE, which also kills mem_we.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and state-decoded outputs.
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op_legal) begin
                        state_next = ST_WRITE;
                    end else if (in_last) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                if (pend_last || (mem_addr == LAST_ADDR)) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (clear) begin
            state_next = ST_IDLE;
        end
    end

    // Write-port registers, address/count bookkeeping and the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= 8'h00;
            mem_wdata <= 32'h0000_0000;
            next_addr <= 8'h00;
            pend_last <= 1'b0;
            count     <= 9'd0;
            err       <= 1'b0;
        end else if (clear) begin
            // Restart of a program load; an in-flight write is dropped uncounted.
            mem_addr  <= 8'h00;
            mem_wdata <= 32'h0000_0000;
            next_addr <= 8'h00;
            pend_last <= 1'b0;
            count     <= 9'd0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                if (op_legal) begin
                    mem_addr  <= next_addr;
                    mem_wdata <= enc_word;
                    pend_last <= in_last;
                end else begin
                    err <= 1'b1;
                end
            end
            if (state == ST_WRITE) begin
                count <= count + 9'd1;
                if (mem_addr == LAST_ADDR) begin
                    // Memory is full: no wrap, and running out without in_last
                    // is an overflow.
                    if (!pend_last) begin
                        err <= 1'b1;
                    end
                end else begin
                    next_addr <= mem_addr + 8'd1;
                end
            end
        end
    end

endmodule
